// File: rtl/io_decimal_display.sv
// Converts the output-latch value to eight 7-segment decimal digits.
// A sequential double-dabble engine does one shift per clock.
module io_decimal_display #(
    parameter int BLANK_LZ       = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] IO_RAMOutput,
    input  logic        IO_RAMwrite,
    output logic [55:0] hex_segments,
    output logic        busy,
    output logic        done,
    output logic        overflow
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        UPDATE
    } state_t;

    localparam logic [55:0] SEG_BLANK = {56{SEG_ACTIVE_LOW != 0}};

    state_t      state;
    logic [31:0] bin;
    logic [39:0] bcd;
    logic [5:0]  cnt;
    logic        pend_valid;
    logic [31:0] pend_val;
    logic [39:0] bcd_adj;
    logic [55:0] seg_next;

    function automatic logic [6:0] encode(input logic [3:0] d);
        case (d)
            4'd0:    encode = 7'h3F;
            4'd1:    encode = 7'h06;
            4'd2:    encode = 7'h5B;
            4'd3:    encode = 7'h4F;
            4'd4:    encode = 7'h66;
            4'd5:    encode = 7'h6D;
            4'd6:    encode = 7'h7D;
            4'd7:    encode = 7'h07;
            4'd8:    encode = 7'h7F;
            4'd9:    encode = 7'h6F;
            default: encode = 7'h00;
        endcase
    endfunction

    always_comb begin
        bcd_adj = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            else
                bcd_adj[4*i +: 4] = bcd[4*i +: 4];
        end
    end

    // Walk from the most significant displayed digit down so that the
    // leading-zero run is known when each digit is encoded.
    always_comb begin
        logic        lead_zero;
        logic [3:0]  d;
        logic [6:0]  seg;
        int unsigned k;
        seg_next  = '0;
        lead_zero = 1'b1;
        for (int unsigned i = 0; i < 8; i++) begin
            k         = 7 - i;
            d         = bcd[4*k +: 4];
            lead_zero = lead_zero && (d == 4'd0);
            seg       = encode(d);
            if (BLANK_LZ != 0 && k != 0 && lead_zero)
                seg = 7'h00;
            if (SEG_ACTIVE_LOW != 0)
                seg = ~seg;
            seg_next[7*k +: 7] = seg;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            bin          <= '0;
            bcd          <= '0;
            cnt          <= '0;
            pend_valid   <= 1'b0;
            pend_val     <= '0;
            hex_segments <= SEG_BLANK;
            busy         <= 1'b0;
            done         <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && IO_RAMwrite) begin
                pend_valid <= 1'b1;
                pend_val   <= IO_RAMOutput;
            end
            case (state)
                IDLE: begin
                    if (IO_RAMwrite || pend_valid) begin
                        bin        <= IO_RAMwrite ? IO_RAMOutput : pend_val;
                        bcd        <= '0;
                        cnt        <= '0;
                        pend_valid <= 1'b0;
                        busy       <= 1'b1;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd, bin} <= {bcd_adj[38:0], bin, 1'b0};
                    cnt        <= cnt + 6'd1;
                    if (cnt == 6'd31)
                        state <= UPDATE;
                end
                UPDATE: begin
                    hex_segments <= seg_next;
                    overflow     <= |bcd[39:32];
                    done         <= 1'b1;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_io_decimal_display.sv
// Bench for io_decimal_display: arithmetic display model plus directed vectors.
module tb_io_decimal_display;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] IO_RAMOutput = '0;
    logic        IO_RAMwrite = 1'b0;
    logic [55:0] hex_a, hex_b;
    logic        busy_a, done_a, ovf_a;
    logic        busy_b, done_b, ovf_b;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    always #5 clock = ~clock;

    io_decimal_display #(.BLANK_LZ(1), .SEG_ACTIVE_LOW(1)) dut_a (
        .clock(clock), .reset(reset), .IO_RAMOutput(IO_RAMOutput), .IO_RAMwrite(IO_RAMwrite),
        .hex_segments(hex_a), .busy(busy_a), .done(done_a), .overflow(ovf_a)
    );

    io_decimal_display #(.BLANK_LZ(0), .SEG_ACTIVE_LOW(0)) dut_b (
        .clock(clock), .reset(reset), .IO_RAMOutput(IO_RAMOutput), .IO_RAMwrite(IO_RAMwrite),
        .hex_segments(hex_b), .busy(busy_b), .done(done_b), .overflow(ovf_b)
    );

    localparam logic [6:0] SEG_TBL [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Model: a conversion is a 33-edge countdown that ends in value mod 1e8.
    int          m_left;
    logic [31:0] m_val;
    bit          m_pend;
    logic [31:0] m_pend_val;
    bit          m_have;
    logic [31:0] m_shown;
    bit          m_done;
    bit          m_ovf;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_left = 0; m_pend = 0; m_have = 0; m_shown = 0; m_done = 0; m_ovf = 0;
        end else begin
            m_done = 0;
            if (m_left == 0) begin
                if (IO_RAMwrite || m_pend) begin
                    m_val  = IO_RAMwrite ? IO_RAMOutput : m_pend_val;
                    m_pend = 0;
                    m_left = 33;
                end
            end else begin
                if (IO_RAMwrite) begin
                    m_pend     = 1;
                    m_pend_val = IO_RAMOutput;
                end
                m_left--;
                if (m_left == 0) begin
                    m_have  = 1;
                    m_shown = m_val % 32'd100000000;
                    m_ovf   = (m_val >= 32'd100000000);
                    m_done  = 1;
                end
            end
        end
    end

    function automatic logic [55:0] exp_segs(input bit have, input logic [31:0] v,
                                             input bit blank, input bit al);
        logic [55:0]     r;
        logic [6:0]      s;
        longint unsigned p;
        int unsigned     d;
        r = '0;
        p = 1;
        for (int k = 0; k < 8; k++) begin
            d = int'((longint'(v) / p) % 10);
            s = have ? SEG_TBL[d] : 7'h00;
            if (have && blank && k > 0 && longint'(v) < p)
                s = 7'h00;
            r[7*k +: 7] = al ? ~s : s;
            p = p * 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [55:0] act, input logic [55:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clock) begin
        chk("model_hex_a", hex_a, exp_segs(m_have, m_shown, 1'b1, 1'b1));
        chk("model_hex_b", hex_b, exp_segs(m_have, m_shown, 1'b0, 1'b0));
        chk("model_busy_a", 56'(busy_a), 56'(m_left != 0));
        chk("model_busy_b", 56'(busy_b), 56'(m_left != 0));
        chk("model_done_a", 56'(done_a), 56'(m_done));
        chk("model_done_b", 56'(done_b), 56'(m_done));
        chk("model_ovf_a", 56'(ovf_a), 56'(m_ovf));
        chk("model_ovf_b", 56'(ovf_b), 56'(m_ovf));
        if (done_a) done_cnt++;
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic strobe(input logic [31:0] v);
        IO_RAMOutput = v;
        IO_RAMwrite  = 1'b1;
        step(1);
        IO_RAMwrite  = 1'b0;
    endtask

    localparam logic [55:0] RST_A = 56'hFF_FFFF_FFFF_FFFF;

    initial begin
        // 1. reset
        step(3);
        chk("rst_hex_a", hex_a, RST_A);
        chk("rst_hex_b", hex_b, 56'h0);
        chk("rst_flags", {53'h0, busy_a, done_a, ovf_a}, 56'h0);
        reset = 1'b1;
        step(2);
        chk("rel_hex_a", hex_a, RST_A);

        // 2. 1234
        strobe(32'd1234);
        chk("t2_busy", 56'(busy_a), 56'h1);
        step(33);
        chk("t2_hex_a", hex_a, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19});
        chk("t2_hex_b", hex_b, {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66});
        chk("t2_done", 56'(done_a), 56'h1);
        chk("t2_busy_end", 56'(busy_a), 56'h0);
        step(1);
        chk("t2_done_end", 56'(done_a), 56'h0);

        // 3. zero
        strobe(32'd0);
        step(33);
        chk("t3_hex_a", hex_a, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
        chk("t3_hex_b", hex_b, {8{7'h3F}});

        // 4. overflow then small value
        strobe(32'hFFFF_FFFF);
        step(33);
        chk("t4_ovf", 56'(ovf_a), 56'h1);
        chk("t4_hex_a", hex_a, {7'h10, 7'h19, 7'h10, 7'h02, 7'h78, 7'h24, 7'h10, 7'h12});
        strobe(32'd7);
        step(33);
        chk("t4b_ovf", 56'(ovf_a), 56'h0);
        chk("t4b_hex_a", hex_a, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78});

        // 5. strobes while busy: last write wins
        step(2);
        done_cnt = 0;
        strobe(32'd5);
        step(9);
        strobe(32'd77);
        step(9);
        strobe(32'd88);
        step(13);
        chk("t5_hex_5", hex_a, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h12});
        chk("t5_done1", 56'(done_a), 56'h1);
        step(1);
        chk("t5_busy_pend", 56'(busy_a), 56'h1);
        step(33);
        chk("t5_hex_88", hex_a, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h00, 7'h00});
        chk("t5_done2", 56'(done_a), 56'h1);
        step(5);
        chk("t5_done_count", 56'(done_cnt), 56'd2);
        chk("t5_idle", 56'(busy_a), 56'h0);

        // 6. reset mid-conversion
        strobe(32'd1234);
        step(33);
        strobe(32'd999);
        step(14);
        reset = 1'b0;
        step(2);
        chk("t6_rst_hex", hex_a, RST_A);
        chk("t6_rst_flags", {53'h0, busy_a, done_a, ovf_a}, 56'h0);
        reset = 1'b1;
        step(1);
        strobe(32'd42);
        step(33);
        chk("t6_hex_42", hex_a, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24});
        step(40);
        chk("t6_hold", hex_a, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
